ahb_sram_if: RTL and testbench
==============================

Name: ahb_sram_if

Overview:
AHB-Lite slave that bridges single transfers issued by the team's AHB master onto a single-port synchronous SRAM with a 1-cycle read latency. It decodes address-phase controls, generates byte enables and returns read data and handshake to the master. Reads have zero wait states. A read that directly follows a write costs one wait state, because of the SRAM port conflict.

Parameters:
AW, 12, SRAM word-address width (memory = 4*2^AW bytes)

Ports:
hclk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
ahb_sel  input  1  slave select
ahb_readyi  input  1  bus HREADY (previous transfer complete)
ahb_write  input  1  1=write, 0=read
ahb_addr  input  32  byte address
ahb_wdata  input  32  write data (data phase)
ahb_trans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
ahb_size  input  3  BYTE=000, HALF=001, WORD=010
ahb_burst  input  3  burst type; ignored, each beat handled independently
ahb_readyo  output  1  slave HREADYOUT
ahb_rdata  output  32  read data
ahb_resp  output  1  0=OKAY, 1=ERROR
sram_cs  output  1  SRAM chip select
sram_we  output  1  SRAM write enable
sram_be  output  4  SRAM byte enables, bit n = byte lane n
sram_addr  output  AW  SRAM word address
sram_wdata  output  32  SRAM write data
sram_rdata  input  32  SRAM read data, valid the cycle after a read cs

Behaviour:
- Valid transfer: ahb_sel & ahb_readyi & ahb_trans[1]. BUSY and IDLE cause no access and get readyo=1, OKAY.
- Word address is ahb_addr[AW+1:2]. Accesses are forced aligned; low address bits only steer byte enables.
- Byte enables (little-endian):
  - BYTE: 1<<addr[1:0]
  - HALF: addr[1] ? 1100 : 0011
  - WORD: 1111
  - Size > WORD: treated as WORD
- FSM states: IDLE, WR, RDP, RD.
- IDLE / RD, read phase accepted: sram_cs=1, we=0, sram_addr driven combinationally from ahb_addr. Next state RD.
- IDLE / RD / WR, write phase accepted: latch word address and byte enables. Next state WR.
- RD: ahb_rdata = sram_rdata, readyo=1. Back-to-back reads stream at 1 per cycle. Outside RD, ahb_rdata = 32'h0.
- WR: sram_cs=1, we=1, latched addr/be, sram_wdata = ahb_wdata, readyo=1.
  - A new write accepted in WR stays in WR (zero-wait write streaming).
  - A read accepted in WR has its address latched. Next state RDP.
- RDP: readyo=0; SRAM read issued from the latched address. Next state RD.
- No valid transfer, or state RD/WR completes with nothing new: return to IDLE.
- Latency: read data 1 cycle after address phase (2 if preceded by a write); write committed in the data-phase cycle.
- Reset values: readyo=1, resp=OKAY, rdata=0, sram_cs=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0, state IDLE, latches cleared.
- Reset mid-operation: a pending write or read is dropped; no SRAM access occurs in the reset cycle or the cycle after.
- sram_be/sram_addr/sram_wdata are 0 whenever sram_cs=0.

Optional Feature:
AHB_SRAM_ERR_EN
- Defined:
  - A valid transfer with ahb_addr[31:AW+2] != 0 or ahb_size > WORD gets no SRAM access.
  - It gets a two-cycle ERROR: ERR1 (readyo=0, resp=1), then ERR2 (readyo=1, resp=1).
  - Transfers accepted during ERR2 are decoded normally.
  - An error following a write still lets the WR cycle commit first.
- Undefined: high address bits are ignored (address aliasing), oversize is treated as WORD, and resp is tied to 0.

Decomposition:
- Package ahb_sram_pkg: HTRANS/HSIZE/HRESP constants, FSM state encoding (including ERR1/ERR2).
- One sub-module, ahb_sram_be_gen: combinational size+addr[1:0] -> 4-bit byte enable, reused for writes and error/size checks.

Test Plan:
- Write 0x1000_0004 = 0xDEADBEEF (WORD), then read it back -> write sram_cs/we/be=1111/addr=1; read has one wait state (RDP); rdata=0xDEADBEEF.
- BYTE writes 0x11 to addr 0x8 and 0x22 to addr 0xB, then WORD read of 0x8 -> be 0001 then 1000; read returns 0x22xxxx11 with the middle bytes unchanged.
- Four back-to-back reads of 0x0,0x4,0x8,0xC, with the SRAM preloaded 1..4 -> readyo stays 1; rdata 1,2,3,4 on consecutive cycles.
- HALF write 0xABCD to addr 0x6 -> sram_be=1100, addr=1.
- rst_n low for one cycle during the WR state -> no SRAM write (cs=0); outputs at reset values; next transfer works.
- With AHB_SRAM_ERR_EN and AW=12, read 0x0001_0000 -> resp=1 for 2 cycles, readyo 0 then 1, sram_cs never asserted; without the macro -> reads word 0, OKAY.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// rtl/ahb_sram_pkg.sv - shared constants and FSM encoding for the AHB-Lite to SRAM bridge
// Contents: HTRANS / HSIZE / HRESP encodings and the bridge state type (ERR1/ERR2 are
// reachable only when AHB_SRAM_ERR_EN is defined).
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RDP,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_sram_be_gen.sv
// rtl/ahb_sram_be_gen.sv - transfer size + low address bits to little-endian byte enables
// Ports:
//   size     in  3  HSIZE of the transfer
//   addr_lo  in  2  byte offset within the word
//   be       out 4  byte enables, bit n = byte lane n (oversize sizes give a full word)
//   oversize out 1  size is larger than a word
module ahb_sram_be_gen
  import ahb_sram_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       oversize
);

  always_comb begin
    be = 4'b1111;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
  end

  assign oversize = (size > HSIZE_WORD);

endmodule

// File: rtl/ahb_sram_if.sv
// rtl/ahb_sram_if.sv - AHB-Lite slave bridging single transfers onto a 1-cycle-latency SRAM
// Optional feature macro: AHB_SRAM_ERR_EN (out-of-range address / oversize -> two-cycle ERROR).
// Ports:
//   hclk, rst_n                  clock, synchronous active-low reset
//   ahb_sel/readyi/write/addr/wdata/trans/size/burst   AHB-Lite slave inputs
//   ahb_readyo/rdata/resp        AHB-Lite slave outputs (HREADYOUT, HRDATA, HRESP)
//   sram_cs/we/be/addr/wdata     single-port SRAM request (all zero while cs is low)
//   sram_rdata                   SRAM read data, valid the cycle after a read request
module ahb_sram_if
  import ahb_sram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          hclk,
  input  logic          rst_n,
  input  logic          ahb_sel,
  input  logic          ahb_readyi,
  input  logic          ahb_write,
  input  logic [31:0]   ahb_addr,
  input  logic [31:0]   ahb_wdata,
  input  logic [1:0]    ahb_trans,
  input  logic [2:0]    ahb_size,
  input  logic [2:0]    ahb_burst,
  output logic          ahb_readyo,
  output logic [31:0]   ahb_rdata,
  output logic          ahb_resp,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [3:0]    sram_be,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;

  logic          valid;
  logic          can_accept;
  logic          addr_hi_nz;
  logic          oversize;
  logic          err_c;
  logic [3:0]    be_gen;
  logic [AW-1:0] word_addr;

  logic          readyo_c;
  logic          resp_c;
  logic [31:0]   rdata_c;
  logic          cs_c;
  logic          we_c;
  logic [3:0]    sbe_c;
  logic [AW-1:0] saddr_c;
  logic [31:0]   swdata_c;

  // Bursts carry no extra meaning here: every beat is decoded on its own.
  logic unused_burst;
  assign unused_burst = ^ahb_burst;

  ahb_sram_be_gen u_be_gen (
    .size     (ahb_size),
    .addr_lo  (ahb_addr[1:0]),
    .be       (be_gen),
    .oversize (oversize)
  );

  assign valid      = ahb_sel && ahb_readyi &&
                      ((ahb_trans == HTRANS_NONSEQ) || (ahb_trans == HTRANS_SEQ));
  assign word_addr  = ahb_addr[AW+1:2];
  assign addr_hi_nz = |ahb_addr[31:AW+2];
  assign err_c      = ERR_EN && valid && (addr_hi_nz || oversize);
  // Address phases are only taken in states that drive readyo high.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_WR) ||
                      (state_q == ST_RD)   || (state_q == ST_ERR2);

  always_comb begin
    state_d  = ST_IDLE;
    addr_d   = addr_q;
    be_d     = be_q;
    readyo_c = 1'b1;
    resp_c   = HRESP_OKAY;
    rdata_c  = '0;
    cs_c     = 1'b0;
    we_c     = 1'b0;
    sbe_c    = '0;
    saddr_c  = '0;
    swdata_c = '0;

    // Data-phase behaviour of the transfer currently owning the bus.
    case (state_q)
      ST_WR: begin
        cs_c     = 1'b1;
        we_c     = 1'b1;
        saddr_c  = addr_q;
        sbe_c    = be_q;
        swdata_c = ahb_wdata;
      end
      ST_RD: begin
        rdata_c = sram_rdata;
      end
      ST_RDP: begin
        // The read was accepted while the port was busy writing; issue it now.
        readyo_c = 1'b0;
        cs_c     = 1'b1;
        saddr_c  = addr_q;
        sbe_c    = 4'b1111;
        state_d  = ST_RD;
      end
      ST_ERR1: begin
        readyo_c = 1'b0;
        resp_c   = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        resp_c = HRESP_ERROR;
      end
      default: begin
      end
    endcase

    // Address phase of the next transfer (overlaps the data phase above).
    if (can_accept && valid) begin
      if (err_c) begin
        state_d = ST_ERR1;
      end else if (ahb_write) begin
        addr_d  = word_addr;
        be_d    = be_gen;
        state_d = ST_WR;
      end else if (state_q == ST_WR) begin
        addr_d  = word_addr;
        state_d = ST_RDP;
      end else begin
        // SRAM port is free: read straight from the address phase.
        cs_c    = 1'b1;
        saddr_c = word_addr;
        sbe_c   = 4'b1111;
        state_d = ST_RD;
      end
    end

    // Outputs held at reset values while reset is asserted, so a pending
    // write cannot reach the SRAM in the reset cycle.
    if (!rst_n) begin
      readyo_c = 1'b1;
      resp_c   = HRESP_OKAY;
      rdata_c  = '0;
      cs_c     = 1'b0;
      we_c     = 1'b0;
      sbe_c    = '0;
      saddr_c  = '0;
      swdata_c = '0;
    end
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  assign ahb_readyo = readyo_c;
  assign ahb_rdata  = rdata_c;
  assign ahb_resp   = ERR_EN ? resp_c : HRESP_OKAY;
  assign sram_cs    = cs_c;
  assign sram_we    = we_c;
  assign sram_be    = sbe_c;
  assign sram_addr  = saddr_c;
  assign sram_wdata = swdata_c;

endmodule

// File: tb/tb_ahb_sram_if.sv
// tb/tb_ahb_sram_if.sv - scoreboard bench for ahb_sram_if with a behavioural SRAM
module tb_ahb_sram_if;
  import ahb_sram_pkg::*;

  localparam int AW = 12;

`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          hclk = 1'b0;
  logic          rst_n;
  logic          ahb_sel;
  logic          ahb_write;
  logic [31:0]   ahb_addr;
  logic [31:0]   ahb_wdata;
  logic [1:0]    ahb_trans;
  logic [2:0]    ahb_size;
  logic [2:0]    ahb_burst;
  logic          ahb_readyo;
  logic [31:0]   ahb_rdata;
  logic          ahb_resp;
  logic          sram_cs;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = 32'h0;

  always #5 hclk = ~hclk;

  ahb_sram_if #(.AW(AW)) dut (
    .hclk       (hclk),
    .rst_n      (rst_n),
    .ahb_sel    (ahb_sel),
    .ahb_readyi (ahb_readyo),
    .ahb_write  (ahb_write),
    .ahb_addr   (ahb_addr),
    .ahb_wdata  (ahb_wdata),
    .ahb_trans  (ahb_trans),
    .ahb_size   (ahb_size),
    .ahb_burst  (ahb_burst),
    .ahb_readyo (ahb_readyo),
    .ahb_rdata  (ahb_rdata),
    .ahb_resp   (ahb_resp),
    .sram_cs    (sram_cs),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural single-port SRAM, 1-cycle read latency, byte-masked writes.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge hclk) begin
    if (sram_cs && !sram_we) sram_rdata <= mem[sram_addr];
    if (sram_cs && sram_we)
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        resp;
    logic [7:0]  waits;
  } resp_t;

  typedef struct packed {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } sram_t;

  resp_t resp_q[$];
  sram_t sram_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: AHB data-phase completions and SRAM requests.
  bit dp_active = 1'b0;
  int waits = 0;
  always @(negedge hclk) begin
    if (!rst_n) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active) begin
        if (!ahb_readyo) begin
          waits++;
        end else begin
          if (resp_q.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
          end else begin
            resp_t r;
            r = resp_q.pop_front();
            chk("resp_waits", waits, {24'h0, r.waits});
            chk("resp_hresp", {31'h0, ahb_resp}, {31'h0, r.resp});
            chk("resp_rdata", ahb_rdata, r.rdata);
          end
          dp_active = 1'b0;
        end
      end
      if (ahb_sel && ahb_trans[1] && ahb_readyo) begin
        dp_active = 1'b1;
        waits = 0;
      end
      if (sram_cs) begin
        if (sram_q.size() == 0) begin
          chk("sram_unexpected_cs", 32'd1, 32'd0);
        end else begin
          sram_t s;
          s = sram_q.pop_front();
          chk("sram_we", {31'h0, sram_we}, {31'h0, s.we});
          chk("sram_be", {28'h0, sram_be}, {28'h0, s.be});
          chk("sram_addr", {{(32-AW){1'b0}}, sram_addr}, {{(32-AW){1'b0}}, s.addr});
          chk("sram_wdata", sram_wdata, s.wdata);
        end
      end else begin
        chk("sram_idle_zero", {sram_we, sram_be, sram_wdata[26:0] | {{(27-AW){1'b0}}, sram_addr}},
            32'h0);
        chk("sram_idle_wdata", sram_wdata, 32'h0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    forever begin
      @(negedge hclk);
      if (ahb_readyo === 1'b1) break;
      n++;
      if (n >= 16) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual=readyo_low required=readyo_high");
        break;
      end
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] tr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] rdata_exp, input int waits_exp);
    resp_t r;
    sram_t s;
    logic  bad;
    bad = ERR_EN && (((addr >> (AW + 2)) != 32'h0) || (size > 3'd2));
    if (bad) begin
      r.resp  = 1'b1;
      r.waits = 8'd1;
      r.rdata = 32'h0;
    end else begin
      r.resp  = 1'b0;
      r.waits = waits_exp[7:0];
      r.rdata = wr ? 32'h0 : rdata_exp;
      s.we    = wr;
      s.be    = wr ? be : 4'hF;
      s.addr  = addr[AW+1:2];
      s.wdata = wr ? wdata : 32'h0;
      sram_q.push_back(s);
    end
    resp_q.push_back(r);
    ahb_sel   = 1'b1;
    ahb_trans = tr;
    ahb_write = wr;
    ahb_addr  = addr;
    ahb_size  = size;
    wait_ready();
    ahb_wdata = wr ? wdata : 32'h0;
  endtask

  task automatic idle();
    ahb_sel   = 1'b0;
    ahb_trans = HTRANS_IDLE;
    ahb_write = 1'b0;
    ahb_addr  = 32'h0;
    ahb_size  = HSIZE_BYTE;
    wait_ready();
    ahb_wdata = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_readyo"}, {31'h0, ahb_readyo}, 32'd1);
    chk({tag, "_resp"}, {31'h0, ahb_resp}, 32'd0);
    chk({tag, "_rdata"}, ahb_rdata, 32'h0);
    chk({tag, "_cs"}, {31'h0, sram_cs}, 32'd0);
    chk({tag, "_we"}, {31'h0, sram_we}, 32'd0);
    chk({tag, "_be"}, {28'h0, sram_be}, 32'd0);
    chk({tag, "_addr"}, {{(32-AW){1'b0}}, sram_addr}, 32'd0);
    chk({tag, "_wdata"}, sram_wdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = i + 1;
    rst_n     = 1'b0;
    ahb_sel   = 1'b0;
    ahb_write = 1'b0;
    ahb_addr  = 32'h0;
    ahb_wdata = 32'h0;
    ahb_trans = HTRANS_IDLE;
    ahb_size  = HSIZE_BYTE;
    ahb_burst = 3'b000;

    @(posedge hclk);
    @(negedge hclk);
    check_reset_outputs("reset");
    @(posedge hclk);
    #1 rst_n = 1'b1;
    idle();

    // Back-to-back reads of preloaded words 1..4, no wait states.
    ahb_burst = 3'b011;
    issue(1'b0, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 32'h0, 4'h0, 32'd1, 0);
    issue(1'b0, HTRANS_SEQ,    32'h4, HSIZE_WORD, 32'h0, 4'h0, 32'd2, 0);
    issue(1'b0, HTRANS_SEQ,    32'h8, HSIZE_WORD, 32'h0, 4'h0, 32'd3, 0);
    issue(1'b0, HTRANS_SEQ,    32'hC, HSIZE_WORD, 32'h0, 4'h0, 32'd4, 0);
    ahb_burst = 3'b000;
    idle();

    // Word write then read-back: one wait state (RDP).
    issue(1'b1, HTRANS_NONSEQ, 32'h1000_0004, HSIZE_WORD, 32'hDEAD_BEEF, 4'b1111, 32'h0, 0);
    issue(1'b0, HTRANS_NONSEQ, 32'h1000_0004, HSIZE_WORD, 32'h0, 4'h0, 32'hDEAD_BEEF, 1);
    idle();

    // Byte writes to lanes 0 and 3 of word 2, middle bytes preserved.
    mem[2] = 32'h5566_7788;
    issue(1'b1, HTRANS_NONSEQ, 32'h8, HSIZE_BYTE, 32'h0000_0011, 4'b0001, 32'h0, 0);
    issue(1'b1, HTRANS_NONSEQ, 32'hB, HSIZE_BYTE, 32'h2200_0000, 4'b1000, 32'h0, 0);
    issue(1'b0, HTRANS_NONSEQ, 32'h8, HSIZE_WORD, 32'h0, 4'h0, 32'h2266_7711, 1);
    idle();

    // Halfword write to the upper half of word 1.
    issue(1'b1, HTRANS_NONSEQ, 32'h6, HSIZE_HALF, 32'hABCD_0000, 4'b1100, 32'h0, 0);
    idle();

    // Reset asserted during the WR data phase drops the write.
    ahb_sel   = 1'b1;
    ahb_trans = HTRANS_NONSEQ;
    ahb_write = 1'b1;
    ahb_addr  = 32'h10;
    ahb_size  = HSIZE_WORD;
    wait_ready();
    ahb_wdata = 32'hCAFE_F00D;
    rst_n     = 1'b0;
    ahb_sel   = 1'b0;
    ahb_trans = HTRANS_IDLE;
    ahb_write = 1'b0;
    ahb_addr  = 32'h0;
    @(negedge hclk);
    check_reset_outputs("midreset");
    @(posedge hclk);
    #1;
    rst_n     = 1'b1;
    ahb_wdata = 32'h0;
    idle();
    issue(1'b0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h0, 4'h0, 32'h0, 0);
    idle();

    // High address bits: alias to word 0 by default, ERROR when the check is built in.
    issue(1'b0, HTRANS_NONSEQ, 32'h0001_0000, HSIZE_WORD, 32'h0, 4'h0, 32'd1, 0);
    idle();
    idle();

    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("sram_queue_drained", sram_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
